ps2_line_assembler: RTL and testbench

PS2_LINE_ASSEMBLER -- requirements
Module: ps2_line_assembler

---
 rtl/ps2_line_assembler.sv | 114 +++++++++++
 tb/tb_ps2_line_assembler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_line_assembler.sv
// ps2_line_assembler
// Turns a stream of decoded PS/2 keystrokes into 32-character text lines.
// The line being typed (edit_line) is double-buffered against the committed
// line (line_content), so typing can continue while downstream is still
// consuming the previous line.
// Character c occupies bits [255-8c -: 8] of both buffers.

module ps2_line_assembler #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [7:0]   key_ascii,
  input  logic         line_ack,
  output logic [255:0] line_content,
  output logic         line_ready,
  output logic [255:0] edit_line,
  output logic [5:0]   cursor,
  output logic         key_dropped
);

  localparam logic [0:0]   ST_EDIT     = 1'b0;
  localparam logic [0:0]   ST_WAIT_ACK = 1'b1;

  localparam logic [7:0]   KEY_BS      = 8'h08;
  localparam logic [7:0]   KEY_ENTER   = 8'h0D;
  localparam logic [7:0]   KEY_ESC     = 8'h1B;

  localparam logic [5:0]   LINE_LEN    = 6'd32;
  localparam logic [255:0] BLANK_LINE  = {32{BLANK_CHAR}};

  logic [0:0]   state, state_nx;
  logic [255:0] edit_nx, content_nx;
  logic [5:0]   cursor_nx;
  logic         dropped_nx;
  logic         printable;

  assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

  // A committed line stays pending exactly as long as we sit in WAIT_ACK.
  assign line_ready = (state == ST_WAIT_ACK);

  // Next-state decode: acknowledge handling plus one keystroke per edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_nx   = state;
    edit_nx    = edit_line;
    content_nx = line_content;
    cursor_nx  = cursor;
    dropped_nx = 1'b0;

    if (state == ST_WAIT_ACK && line_ack) begin
      state_nx = ST_EDIT;
    end

    if (key_valid) begin
      if (printable) begin
        if (cursor < LINE_LEN) begin
          for (int c = 0; c < 32; c++) begin
            if (6'(c) == cursor) edit_nx[255-8*c -: 8] = key_ascii;
          end
          cursor_nx = cursor + 6'd1;
        end else begin
          dropped_nx = 1'b1;
        end
      end else if (key_ascii == KEY_BS) begin
        if (cursor != 6'd0) begin
          for (int c = 0; c < 32; c++) begin
            if (6'(c) == cursor - 6'd1) edit_nx[255-8*c -: 8] = BLANK_CHAR;
          end
          cursor_nx = cursor - 6'd1;
        end
      end else if (key_ascii == KEY_ESC) begin
        edit_nx   = BLANK_LINE;
        cursor_nx = 6'd0;
      end else if (key_ascii == KEY_ENTER) begin
        // Enter while a line is still pending is refused, even if the ack
        // arrives on this very edge; the ack alone is honoured.
        if (state == ST_WAIT_ACK) begin
          dropped_nx = 1'b1;
        end else if (cursor != 6'd0) begin
          content_nx = edit_line;
          edit_nx    = BLANK_LINE;
          cursor_nx  = 6'd0;
          state_nx   = ST_WAIT_ACK;
        end
      end
    end
  end

  // State and buffer registers; reset wins over any keystroke or ack.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the decode block.
    if (reset) begin
      // NOTE: both buffers are plain flop banks, not RAM, so clearing them to
      // blanks on reset is legitimate and required for a clean display.
      state        <= ST_EDIT;
      edit_line    <= BLANK_LINE;
      line_content <= BLANK_LINE;
      cursor       <= 6'd0;
      key_dropped  <= 1'b0;
    end else begin
      state        <= state_nx;
      edit_line    <= edit_nx;
      line_content <= content_nx;
      cursor       <= cursor_nx;
      key_dropped  <= dropped_nx;
    end
  end

endmodule

// File: tb/tb_ps2_line_assembler.sv
// tb_ps2_line_assembler
// Directed scenarios plus randomized keystrokes, compared every cycle with a
// queue-based model of the typed text and the pending committed line.

module tb_ps2_line_assembler;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [7:0]   key_ascii = 8'h00;
  logic         line_ack = 1'b0;
  logic [255:0] line_content;
  logic         line_ready;
  logic [255:0] edit_line;
  logic [5:0]   cursor;
  logic         key_dropped;

  int checks   = 0;
  int failures = 0;

  // Model: typed characters and committed characters kept as queues.
  logic [7:0] m_text[$];
  logic [7:0] m_line[$];
  bit         m_ready   = 1'b0;
  bit         m_dropped = 1'b0;

  localparam logic [255:0] BLANKS = {32{8'h20}};

  ps2_line_assembler #(.BLANK_CHAR(8'h20)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ascii   (key_ascii),
    .line_ack    (line_ack),
    .line_content(line_content),
    .line_ready  (line_ready),
    .edit_line   (edit_line),
    .cursor      (cursor),
    .key_dropped (key_dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] render(input logic [7:0] q[$]);
    logic [255:0] v;
    v = BLANKS;
    for (int c = 0; c < q.size(); c++) v[255-8*c -: 8] = q[c];
    return v;
  endfunction

  // Apply the keystroke/ack/reset rules to the model for one clock edge.
  task automatic model_edge(input bit kv, input logic [7:0] k, input bit ack, input bit rst);
    bit was_ready;
    if (rst) begin
      m_text.delete();
      m_line.delete();
      m_ready   = 1'b0;
      m_dropped = 1'b0;
      return;
    end
    was_ready = m_ready;
    m_dropped = 1'b0;
    if (was_ready && ack) m_ready = 1'b0;
    if (kv) begin
      if (k >= 8'h20 && k <= 8'h7E) begin
        if (m_text.size() < 32) m_text.push_back(k);
        else m_dropped = 1'b1;
      end else if (k == 8'h08) begin
        if (m_text.size() > 0) void'(m_text.pop_back());
      end else if (k == 8'h1B) begin
        m_text.delete();
      end else if (k == 8'h0D) begin
        if (was_ready) m_dropped = 1'b1;
        else if (m_text.size() > 0) begin
          m_line  = m_text;
          m_text.delete();
          m_ready = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare everything.
  task automatic step(input bit kv, input logic [7:0] k, input bit ack, input bit rst);
    key_valid = kv;
    key_ascii = k;
    line_ack  = ack;
    reset     = rst;
    @(posedge clock);
    #1;
    model_edge(kv, k, ack, rst);
    check("line_content", line_content, render(m_line));
    check("edit_line",    edit_line,    render(m_text));
    check("cursor",       256'(cursor), 256'(m_text.size()));
    check("line_ready",   256'(line_ready), 256'(m_ready));
    check("key_dropped",  256'(key_dropped), 256'(m_dropped));
    key_valid = 1'b0;
    line_ack  = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic key(input logic [7:0] k);
    step(1'b1, k, 1'b0, 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [255:0] saved;
    logic [7:0]   k;

    // Reset state.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_ready",  256'(line_ready), 256'(0));
    check("rst_cursor", 256'(cursor), 256'(0));
    check("rst_edit",   edit_line, BLANKS);
    check("rst_line",   line_content, BLANKS);

    // 'L','S', enter commits the line.
    key(8'h4C); key(8'h53); key(8'h0D);
    check("ls_head",   256'(line_content[255:240]), 256'(16'h4C53));
    check("ls_tail",   256'(line_content[239:0]), 256'({30{8'h20}}));
    check("ls_ready",  256'(line_ready), 256'(1));
    check("ls_cursor", 256'(cursor), 256'(0));
    check("ls_edit",   edit_line, BLANKS);
    ack();
    check("ls_acked",  256'(line_ready), 256'(0));

    // 33 'A's: full line, only the last key dropped.
    for (int i = 0; i < 33; i++) begin
      key(8'h41);
      check("full_drop", 256'(key_dropped), 256'(i == 32));
    end
    check("full_cursor", 256'(cursor), 256'(32));
    check("full_edit",   edit_line, {32{8'h41}});
    key(8'h1B);
    check("esc_edit", edit_line, BLANKS);

    // Backspace past the start is a silent no-op.
    key(8'h41); key(8'h42);
    for (int i = 0; i < 3; i++) begin
      key(8'h08);
      check("bs_drop", 256'(key_dropped), 256'(0));
    end
    check("bs_cursor", 256'(cursor), 256'(0));
    check("bs_edit",   edit_line, BLANKS);

    // Enter with an empty line does nothing.
    key(8'h0D);
    check("empty_enter", 256'(line_ready), 256'(0));

    // Enter while pending is dropped; typing continues in the edit buffer.
    key(8'h58); key(8'h0D); key(8'h59); key(8'h0D);
    check("pend_drop",  256'(key_dropped), 256'(1));
    check("pend_line0", 256'(line_content[255:248]), 256'(8'h58));
    check("pend_edit0", 256'(edit_line[255:248]), 256'(8'h59));
    ack();
    check("pend_ack", 256'(line_ready), 256'(0));
    key(8'h1B);

    // Ack and enter on the same edge: ack taken, enter dropped.
    key(8'h5A); key(8'h0D);
    saved = line_content;
    key(8'h51);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("both_ready", 256'(line_ready), 256'(0));
    check("both_drop",  256'(key_dropped), 256'(1));
    check("both_line",  line_content, saved);
    key(8'h0D);
    check("both_edit_state", 256'(line_ready), 256'(1));
    ack();

    // Reset while pending with five characters typed.
    key(8'h57); key(8'h0D);
    for (int i = 0; i < 5; i++) key(8'h61 + 8'(i));
    check("pre_rst_cursor", 256'(cursor), 256'(5));
    step(1'b1, 8'h0D, 1'b1, 1'b1);
    check("rst_w_ready",  256'(line_ready), 256'(0));
    check("rst_w_cursor", 256'(cursor), 256'(0));
    check("rst_w_edit",   edit_line, BLANKS);
    check("rst_w_line",   line_content, BLANKS);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if      (sel < 55) k = 8'($urandom_range(8'h20, 8'h7E));
      else if (sel < 70) k = 8'h08;
      else if (sel < 73) k = 8'h1B;
      else if (sel < 85) k = 8'h0D;
      else               k = 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) < 8, k, $urandom_range(0, 9) < 2,
           $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
